lookup_rule_param: RTL and testbench

Parametrised rule/action lookup table: maps an incoming count/rule ID to an action word for the user-module pipeline, with table contents written and read over the localbus. It generalises the fixed 64×32 rule lookup with configurable depth and action width, per-entry valid bits, a programmable default action, a hit flag, and a lookup counter readable over the localbus. It sits between the ID-classification stage and the action-execution stage.

---
 rtl/lookup_rule_param.sv | 187 ++++++++++++++++++
 tb/tb_lookup_rule_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lookup_rule_param.sv
// lookup_rule_param
//   Parametrised rule/action table between the ID-classification stage and
//   the action-execution stage. A count/rule ID is looked up in a
//   2^ADDR_W-entry table of {valid, action} words; valid entries return their
//   action with a hit flag, invalid entries return the programmable default
//   action. Table contents, the default action and a 32-bit lookup counter
//   are accessed over the localbus.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   countid_valid/countid lookup request strobe and table index
//   action_valid/action/action_hit  lookup result, two cycles after request
//   localbus_cs_n, localbus_rd_wr, localbus_data, localbus_ale  bus inputs
//   localbus_ack_n, localbus_data_out                           bus outputs
module lookup_rule_param #(
    parameter int ADDR_W   = 6,
    parameter int ACTION_W = 16,
    parameter int SEL_BIT  = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                countid_valid,
    input  logic [ADDR_W-1:0]   countid,
    output logic                action_valid,
    output logic [ACTION_W-1:0] action,
    output logic                action_hit,
    input  logic                localbus_cs_n,
    input  logic                localbus_rd_wr,
    input  logic [31:0]         localbus_data,
    input  logic                localbus_ale,
    output logic                localbus_ack_n,
    output logic [31:0]         localbus_data_out
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE, WR, RD, RD_W1, RD_W2, RD_OUT, WAIT_BACK
    } bus_state_t;

    logic [ACTION_W-1:0] act_mem [DEPTH];
    logic [DEPTH-1:0]    vld_mem;
    logic [ACTION_W-1:0] default_action;
    logic [31:0]         lookup_cnt;

    bus_state_t          state;
    logic [ADDR_W:0]     addr_q;
    logic [ADDR_W-1:0]   tbl_idx;
    logic                sel_tbl, sel_def, sel_cnt;
    logic                bus_wr, bus_rd;
    logic [31:0]         rd_mux;
    logic [31:0]         rd_buf;

    logic                vld_p0, ent_vld_p0;
    logic [ACTION_W-1:0] ent_act_p0;
    logic                vld_p1, hit_p1;
    logic [ACTION_W-1:0] act_p1;

    // Bus word bits outside the latched address / write fields are don't-care.
    logic unused_data;
    assign unused_data = ^localbus_data;

    assign tbl_idx = addr_q[ADDR_W-1:0];
    assign sel_tbl = !addr_q[ADDR_W];
    assign sel_def = addr_q[ADDR_W] && (addr_q[1:0] == 2'd0);
    assign sel_cnt = addr_q[ADDR_W] && (addr_q[1:0] == 2'd1);
    assign bus_wr  = (state == WR) && !localbus_cs_n;
    assign bus_rd  = (state == RD) && !localbus_cs_n;

    // Action storage carries no reset; only the valid bits gate its use.
    always_ff @(posedge clk) begin
        if (bus_wr && sel_tbl)
            act_mem[tbl_idx] <= localbus_data[ACTION_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_mem        <= '0;
            default_action <= '0;
            lookup_cnt     <= '0;
        end else begin
            if (bus_wr && sel_tbl)
                vld_mem[tbl_idx] <= localbus_data[31];
            if (bus_wr && sel_def)
                default_action <= localbus_data[ACTION_W-1:0];
            // A counter clear beats a coincident lookup.
            if (bus_wr && sel_cnt)
                lookup_cnt <= '0;
            else if (countid_valid)
                lookup_cnt <= lookup_cnt + 32'd1;
        end
    end

    // ---- stage p0: table read (sees pre-write contents on a same-cycle write)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= countid_valid;
    end

    always_ff @(posedge clk) begin
        ent_vld_p0 <= vld_mem[countid];
        ent_act_p0 <= act_mem[countid];
    end

    // ---- stage p1: registered result, held while no result is presented
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            act_p1 <= '0;
            hit_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                act_p1 <= ent_vld_p0 ? ent_act_p0 : default_action;
                hit_p1 <= ent_vld_p0;
            end
        end
    end

    assign action_valid = vld_p1;
    assign action       = act_p1;
    assign action_hit   = hit_p1;

    always_comb begin
        rd_mux = '0;
        if (sel_tbl) begin
            rd_mux[31]           = vld_mem[tbl_idx];
            rd_mux[ACTION_W-1:0] = act_mem[tbl_idx];
        end else if (sel_def) begin
            rd_mux[ACTION_W-1:0] = default_action;
        end else if (sel_cnt) begin
            rd_mux = lookup_cnt;
        end
    end

    // Read data is captured when the read is issued, then presented after
    // the two wait states.
    always_ff @(posedge clk) begin
        if (bus_rd)
            rd_buf <= rd_mux;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            addr_q            <= '0;
            localbus_ack_n    <= 1'b1;
            localbus_data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (localbus_ale && localbus_data[SEL_BIT]) begin
                        addr_q <= localbus_data[ADDR_W:0];
                        state  <= localbus_rd_wr ? RD : WR;
                    end
                end
                WR: begin
                    if (!localbus_cs_n) begin
                        localbus_ack_n <= 1'b0;
                        state          <= WAIT_BACK;
                    end
                end
                RD: begin
                    if (!localbus_cs_n)
                        state <= RD_W1;
                end
                RD_W1: state <= RD_W2;
                RD_W2: state <= RD_OUT;
                RD_OUT: begin
                    localbus_data_out <= rd_buf;
                    localbus_ack_n    <= 1'b0;
                    state             <= WAIT_BACK;
                end
                WAIT_BACK: begin
                    if (localbus_cs_n) begin
                        localbus_ack_n <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lookup_rule_param.sv
// Testbench for lookup_rule_param: scoreboard of expected lookup results
// (action, hit, issue cycle) checked as results emerge, plus directed
// localbus transactions with handshake timing checks.
module tb_lookup_rule_param;

    localparam int ADDR_W   = 6;
    localparam int ACTION_W = 16;
    localparam int SEL_BIT  = 18;
    localparam int A_DEF    = 64;
    localparam int A_CNT    = 65;
    localparam int A_OFF2   = 66;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                countid_valid = 1'b0;
    logic [ADDR_W-1:0]   countid = '0;
    logic                action_valid;
    logic [ACTION_W-1:0] action;
    logic                action_hit;
    logic                localbus_cs_n = 1'b1;
    logic                localbus_rd_wr = 1'b1;
    logic [31:0]         localbus_data = '0;
    logic                localbus_ale = 1'b0;
    logic                localbus_ack_n;
    logic [31:0]         localbus_data_out;

    lookup_rule_param #(.ADDR_W(ADDR_W), .ACTION_W(ACTION_W), .SEL_BIT(SEL_BIT)) dut (
        .clk(clk), .reset(reset),
        .countid_valid(countid_valid), .countid(countid),
        .action_valid(action_valid), .action(action), .action_hit(action_hit),
        .localbus_cs_n(localbus_cs_n), .localbus_rd_wr(localbus_rd_wr),
        .localbus_data(localbus_data), .localbus_ale(localbus_ale),
        .localbus_ack_n(localbus_ack_n), .localbus_data_out(localbus_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACTION_W-1:0] act;
        logic                hit;
        int                  cyc;
    } exp_t;

    exp_t                sb[$];
    logic                m_valid [64];
    logic [ACTION_W-1:0] m_act   [64];
    logic [ACTION_W-1:0] m_def;
    int                  m_cnt;
    int                  cyc = 0;
    int                  n_vec = 0;
    int                  n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.act = m_valid[idx] ? m_act[idx] : m_def;
        e.hit = m_valid[idx];
        e.cyc = cyc;
        sb.push_back(e);
        m_cnt++;
    endtask

    task automatic model_write(input int addr, input logic [31:0] wd);
        if (addr < 64) begin
            m_valid[addr] = wd[31];
            m_act[addr]   = wd[ACTION_W-1:0];
        end else if (addr == A_DEF) begin
            m_def = wd[ACTION_W-1:0];
        end else if (addr == A_CNT) begin
            m_cnt = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_def = '0;
        m_cnt = 0;
    endtask

    task automatic lookup(input int idx);
        countid_valid = 1'b1;
        countid       = ADDR_W'(idx);
        push_exp(idx);
        @(posedge clk); #1;
        countid_valid = 1'b0;
    endtask

    task automatic addr_phase(input int addr, input logic rd);
        localbus_ale   = 1'b1;
        localbus_rd_wr = rd;
        localbus_data  = (32'h1 << SEL_BIT) | 32'(addr);
        @(posedge clk); #1;
        localbus_ale   = 1'b0;
    endtask

    // lk >= 0 issues a lookup of index lk in the same cycle the write lands.
    task automatic bus_write(input int addr, input logic [31:0] wd, input int lk);
        int n;
        addr_phase(addr, 1'b0);
        localbus_data = wd;
        localbus_cs_n = 1'b0;
        if (lk >= 0) begin
            countid_valid = 1'b1;
            countid       = ADDR_W'(lk);
            push_exp(lk);
        end
        model_write(addr, wd);
        @(posedge clk); #1;
        countid_valid = 1'b0;
        n = 1;
        while (localbus_ack_n && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wr_ack_latency", 32'(n), 32'd1);
        localbus_cs_n = 1'b1;
        @(posedge clk); #1;
        chk("wr_ack_release", 32'(localbus_ack_n), 32'd1);
    endtask

    task automatic bus_read(input int addr, input logic [31:0] exp, input string tag);
        int n;
        addr_phase(addr, 1'b1);
        localbus_cs_n = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (localbus_ack_n && n < 20);
        chk("rd_ack_latency", 32'(n), 32'd4);
        chk(tag, localbus_data_out, exp);
        @(posedge clk); #1;
        chk("rd_ack_hold", 32'(localbus_ack_n), 32'd0);
        localbus_cs_n = 1'b1;
        @(posedge clk); #1;
        chk("rd_ack_release", 32'(localbus_ack_n), 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && action_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("action", 32'(action), 32'(e.act));
                chk("action_hit", 32'(action_hit), 32'(e.hit));
                chk("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 0; i < 64; i++) m_act[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_action_valid", 32'(action_valid), 32'd0);
        chk("rst_action", 32'(action), 32'd0);
        chk("rst_action_hit", 32'(action_hit), 32'd0);
        chk("rst_ack_n", 32'(localbus_ack_n), 32'd1);
        chk("rst_data_out", localbus_data_out, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Miss with default 0.
        lookup(5);
        repeat (3) @(posedge clk); #1;

        // Hit then miss back to back.
        bus_write(5, 32'h8000_1234, -1);
        bus_write(A_DEF, 32'h0000_00AB, -1);
        lookup(5);
        lookup(6);
        repeat (3) @(posedge clk); #1;

        bus_read(5, 32'h8000_1234, "rd_entry5");

        // Same-cycle write and lookup returns the old contents.
        bus_write(7, 32'h8000_1111, -1);
        bus_write(7, 32'h8000_5555, 7);
        repeat (3) @(posedge clk); #1;
        lookup(7);
        repeat (3) @(posedge clk); #1;

        // Counter: clear, 10 lookups, read; then clear racing a lookup.
        bus_write(A_CNT, 32'h0, -1);
        for (int i = 0; i < 10; i++) lookup(i * 3);
        repeat (3) @(posedge clk); #1;
        bus_read(A_CNT, 32'd10, "rd_counter10");
        bus_write(A_CNT, 32'hFFFF_FFFF, 12);
        repeat (3) @(posedge clk); #1;
        bus_read(A_CNT, 32'd0, "rd_counter_clr");

        bus_read(A_OFF2, 32'h0, "rd_unmapped");
        bus_write(A_OFF2, 32'hDEAD_BEEF, -1);
        bus_read(A_DEF, 32'h0000_00AB, "rd_default");

        // Reset while the read is in its first wait state.
        addr_phase(5, 1'b1);
        localbus_cs_n = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_ack_n", 32'(localbus_ack_n), 32'd1);
        chk("mid_rst_data_out", localbus_data_out, 32'd0);
        chk("mid_rst_action", 32'(action), 32'd0);
        chk("mid_rst_action_valid", 32'(action_valid), 32'd0);
        @(posedge clk); #1;
        localbus_cs_n = 1'b1;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("post_rst_ack_n", 32'(localbus_ack_n), 32'd1);
        bus_read(5, 32'h0000_1234, "rd_entry5_after_rst");
        bus_read(A_CNT, 32'd0, "rd_counter_after_rst");
        lookup(5);
        repeat (4) @(posedge clk); #1;

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
